// File: rtl/id_queue_pkg.sv
// id_queue_pkg: shared CPU decode-field types reused by the ID stage
package id_queue_pkg;

  typedef struct packed {
    logic [15:0] imm16;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } dec_fields_t;

  function automatic dec_fields_t decode_fields(input logic [31:0] instr);
    decode_fields = '{imm16: instr[15:0], rs: instr[25:21], rt: instr[20:16], rd: instr[15:11]};
  endfunction

endpackage

// File: rtl/id_queue.sv
// id_queue: IF/ID instruction FIFO with decoded head fields, flush and full/empty by count
module id_queue
  import id_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ID_Flush,
  input  logic                     IF_Valid,
  input  logic [DATA_W-1:0]        IF_Instr,
  input  logic [DATA_W-1:0]        IF_PC,
  output logic                     IF_Ready,
  input  logic                     ID_Wr,
  output logic                     ID_Valid,
  output logic [DATA_W-1:0]        ID_Instr,
  output logic [15:0]              ID_Imm16,
  output logic [4:0]               ID_rs,
  output logic [4:0]               ID_rt,
  output logic [4:0]               ID_rd,
  output logic [DATA_W-1:0]        ID_PC,
  output logic [$clog2(DEPTH):0]   ID_Count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [DATA_W-1:0] pc_mem    [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              enq, deq;
  dec_fields_t       head_f;
  assign ID_Count = count;
  assign IF_Ready = count != CW'(DEPTH);
  assign ID_Valid = count != '0;
  assign enq      = IF_Valid && IF_Ready;
  assign deq      = ID_Wr && ID_Valid;
  // pointers and occupancy; reset beats flush, flush beats traffic
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (ID_Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(enq) - CW'(deq);
    end
  end
  // storage needs no reset: contents are masked while the queue is empty
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr] <= IF_Instr;
      pc_mem[wr_ptr]    <= IF_PC;
    end
  end
  // head presentation, forced to zero when nothing is buffered
  always_comb begin
    head_f   = decode_fields(32'(instr_mem[rd_ptr]));
    ID_Instr = ID_Valid ? instr_mem[rd_ptr] : '0;
    ID_PC    = ID_Valid ? pc_mem[rd_ptr] : '0;
    ID_Imm16 = ID_Valid ? head_f.imm16 : '0;
    ID_rs    = ID_Valid ? head_f.rs : '0;
    ID_rt    = ID_Valid ? head_f.rt : '0;
    ID_rd    = ID_Valid ? head_f.rd : '0;
  end
endmodule

// File: tb/tb_id_queue.sv
// tb_id_queue: table-driven vectors with a FIFO scoreboard for id_queue
module tb_id_queue;
  logic        clk = 0;
  logic        rst = 0, ID_Flush = 0, IF_Valid = 0, ID_Wr = 0;
  logic [31:0] IF_Instr = 0, IF_PC = 0;
  logic        IF_Ready, ID_Valid;
  logic [31:0] ID_Instr, ID_PC;
  logic [15:0] ID_Imm16;
  logic [4:0]  ID_rs, ID_rt, ID_rd;
  logic [2:0]  ID_Count;

  typedef struct {
    logic        r, fl, v, wr;
    logic [31:0] instr, pc;
    int          ec;
  } vec_t;

  typedef struct {
    logic [31:0] instr, pc;
  } ent_t;

  vec_t tbl[$];
  ent_t sb[$];
  int   n_chk = 0, n_fail = 0;
  bit   started = 0;

  id_queue #(.DEPTH(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .ID_Flush(ID_Flush), .IF_Valid(IF_Valid),
    .IF_Instr(IF_Instr), .IF_PC(IF_PC), .IF_Ready(IF_Ready), .ID_Wr(ID_Wr),
    .ID_Valid(ID_Valid), .ID_Instr(ID_Instr), .ID_Imm16(ID_Imm16),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd), .ID_PC(ID_PC), .ID_Count(ID_Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic vec_t mk(input logic r, fl, v, wr, input int k, input int ec);
    vec_t t;
    t.r = r; t.fl = fl; t.v = v; t.wr = wr; t.ec = ec;
    t.instr = {6'h23, 5'(k), 5'(k + 7), 16'(k * 3 + 1)};
    t.pc = 32'h0040_0000 + 32'(k * 4);
    return t;
  endfunction

  task automatic step(input vec_t t);
    ent_t e;
    @(negedge clk);
    rst = t.r; ID_Flush = t.fl; IF_Valid = t.v; ID_Wr = t.wr;
    IF_Instr = t.instr; IF_PC = t.pc;
    #1;
    if (started) begin
      chk("if_ready", IF_Ready, sb.size() != 4);
      if (sb.size() == 0) begin
        chk("empty_valid", ID_Valid, 0);
        chk("empty_instr", ID_Instr, 0);
        chk("empty_pc", ID_PC, 0);
        chk("empty_fields", {ID_Imm16, ID_rs, ID_rt, ID_rd}, 0);
      end else begin
        e = sb[0];
        chk("head_valid", ID_Valid, 1);
        chk("head_instr", ID_Instr, e.instr);
        chk("head_pc", ID_PC, e.pc);
        chk("head_imm16", ID_Imm16, e.instr & 32'hFFFF);
        chk("head_rs", ID_rs, (e.instr >> 21) & 32'h1F);
        chk("head_rt", ID_rt, (e.instr >> 16) & 32'h1F);
        chk("head_rd", ID_rd, (e.instr >> 11) & 32'h1F);
      end
    end
    if (t.r || t.fl) sb.delete();
    else begin
      bit do_enq, do_deq;
      do_enq = t.v && sb.size() < 4;
      do_deq = t.wr && sb.size() > 0;
      if (do_deq) void'(sb.pop_front());
      if (do_enq) sb.push_back('{instr: t.instr, pc: t.pc});
    end
    @(posedge clk);
    #1;
    started = 1;
    chk("count_tbl", 32'(ID_Count), t.ec);
    chk("count_model", 32'(ID_Count), sb.size());
  endtask

  initial begin
    vec_t t;
    // reset with IF_Valid asserted, then two hand-picked MIPS words
    tbl.push_back(mk(1, 0, 1, 0, 99, 0));
    t = mk(0, 0, 1, 0, 0, 1); t.instr = 32'h8C220004; t.pc = 32'hBFC00000; tbl.push_back(t);
    t = mk(0, 0, 1, 0, 0, 2); t.instr = 32'h00851020; t.pc = 32'hBFC00004; tbl.push_back(t);
    foreach (tbl[i]) step(tbl[i]);
    chk("rst_ready_seen", IF_Ready, 1);
    chk("dec_rs", ID_rs, 1);
    chk("dec_rt", ID_rt, 2);
    chk("dec_imm16", ID_Imm16, 16'h0004);
    chk("dec_pc", ID_PC, 32'hBFC00000);
    tbl.delete();
    tbl.push_back(mk(0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 0, 1, 0, 10 + k, (k < 4) ? k + 1 : 4));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 0, 0, 1, 0, (k < 4) ? 3 - k : 0));
    tbl.push_back(mk(0, 0, 1, 0, 20, 1));
    tbl.push_back(mk(0, 0, 1, 0, 21, 2));
    for (int k = 0; k < 10; k++) tbl.push_back(mk(0, 0, 1, 1, 22 + k, 2));
    tbl.push_back(mk(0, 0, 1, 0, 40, 3));
    tbl.push_back(mk(0, 1, 1, 1, 41, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 50, 1));
    tbl.push_back(mk(0, 0, 1, 0, 51, 2));
    tbl.push_back(mk(1, 1, 1, 1, 52, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0));
    foreach (tbl[i]) step(tbl[i]);
    // full queue drops the extra entry; confirm IF_Ready low while full
    for (int k = 0; k < 5; k++) step(mk(0, 0, 1, 0, 60 + k, (k < 4) ? k + 1 : 4));
    #1;
    chk("full_ready_low", IF_Ready, 0);
    chk("full_valid", ID_Valid, 1);
    for (int k = 0; k < 4; k++) step(mk(0, 0, 0, 1, 0, 3 - k));
    chk("drained_valid", ID_Valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/id_queue.md
ID_QUEUE -- requirements
Module: id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered IF/ID entries (power of 2, >= 2).
REQ-002 SHALL have parameter DATA_W, default 32, instruction and PC width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high (RstEnable).
REQ-005 SHALL have port ID_Flush  input  1  discard all buffered entries (FlushEnable).
REQ-006 SHALL have port IF_Valid  input  1  IF presents an instruction this cycle.
REQ-007 SHALL have port IF_Instr  input  DATA_W  fetched instruction.
REQ-008 SHALL have port IF_PC  input  DATA_W  PC of fetched instruction.
REQ-009 SHALL have port IF_Ready  output  1  queue can accept an entry this cycle.
REQ-010 SHALL have port ID_Wr  input  1  ID consumes the head entry this cycle.
REQ-011 SHALL have port ID_Valid  output  1  head entry present.
REQ-012 SHALL have ports ID_Instr (DATA_W), ID_Imm16 (16), ID_rs (5), ID_rt (5), ID_rd (5), ID_PC (DATA_W), all outputs, head-entry fields.
REQ-013 SHALL have port ID_Count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-014 SHALL store entries in FIFO order; enqueue when IF_Valid && IF_Ready, dequeue when ID_Wr && ID_Valid.
REQ-015 SHALL derive IF_Ready = (ID_Count != DEPTH) from registered state only; no combinational path from ID_Wr to IF_Ready.
REQ-016 SHALL derive ID_Valid = (ID_Count != 0).
REQ-017 SHALL present head fields combinationally from storage: ID_Imm16 = Instr[15:0], ID_rs = Instr[25:21], ID_rt = Instr[20:16], ID_rd = Instr[15:11].
REQ-018 SHALL drive ID_Instr, ID_Imm16, ID_rs, ID_rt, ID_rd, ID_PC to all-zero when ID_Valid is 0.
REQ-019 SHALL give an enqueued entry one-cycle latency: written at edge N, visible at head after edge N if queue was empty.
REQ-020 SHALL, on simultaneous enqueue and dequeue (non-full, non-empty), keep ID_Count unchanged and advance both pointers.
REQ-021 SHALL, when empty, ignore ID_Wr; when full, ignore IF_Valid (entry not written, pointers unchanged).
REQ-022 SHALL wrap read/write pointers modulo DEPTH; full/empty distinguished by ID_Count, never by pointer equality alone.
REQ-023 SHALL, on ID_Flush, set ID_Count and both pointers to 0 at next edge; flush takes priority over same-cycle enqueue and dequeue.
REQ-024 SHALL treat ID_Wr with ID_Flush as no-op beyond flush.

Reset
REQ-025 SHALL, on rst at posedge clk, clear pointers and ID_Count to 0, yielding IF_Ready=1, ID_Valid=0, all ID field outputs 0.
REQ-026 SHALL give rst priority over ID_Flush and all traffic; reset mid-operation discards contents.
REQ-027 SHALL not require storage array reset; contents unobservable while invalid per REQ-018.

Structure
REQ-028 SHALL take RstEnable/FlushEnable from the shared defines headers; no new package constants.
REQ-029 SHALL place the instruction-field extraction (imm16/rs/rt/rd) as a decode-field struct typedef in the shared CPU package for reuse by ID stage.
REQ-030 SHALL be a single module; no sub-module.

Verification
REQ-031 SHALL verify reset: assert rst 1 cycle with IF_Valid=1 -> ID_Count=0, IF_Ready=1, ID_Valid=0, ID_Instr=0.
REQ-032 SHALL verify ordering/decode: enqueue 0x8C220004@PC 0xBFC00000 then 0x00851020@0xBFC00004, ID_Wr=1 -> heads in order; first gives rs=1, rt=2, imm16=0x0004.
REQ-033 SHALL verify full: DEPTH=4, 5 enqueues, ID_Wr=0 -> IF_Ready=0 after 4th, 5th dropped, ID_Count=4; then drain yields only first 4.
REQ-034 SHALL verify simultaneous enq/deq at ID_Count=2 for 10 cycles -> ID_Count stays 2, pointers wrap, order preserved.
REQ-035 SHALL verify flush with IF_Valid=1 and ID_Wr=1 at ID_Count=3 -> next cycle ID_Count=0, ID_Valid=0, outputs 0.
REQ-036 SHALL verify empty dequeue: ID_Wr=1 with ID_Count=0 -> ID_Count stays 0, no underflow.
